// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the buffered UART transmitter:
//   uart_state_t   - serializer state encoding (IDLE, START, DATA, STOP)
//   UART_DATA_BITS - payload bits per frame (8N1 framing)
//   uart_cpb()     - clocks per bit from clock frequency and line rate
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

    // Integer truncation is intended: the bit period is rounded down.
    function automatic int uart_cpb(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Write-side and status bundle of uart_tx_fifo.
//   wen, data_in : byte write strobe and byte (master -> slave)
//   tx_busy      : FIFO full, writes are dropped while high
//   tx_idle      : FIFO empty and serializer idle
//   overflow     : sticky, a write was attempted while full
//   level        : FIFO occupancy, $clog2(DEPTH)+1 bits
//   uart_tx      : serial line, idle-high
// DEPTH must match the DEPTH of the uart_tx_fifo it is connected to.
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                      wen;
    logic [UART_DATA_BITS-1:0] data_in;
    logic                      tx_busy;
    logic                      tx_idle;
    logic                      overflow;
    logic [LW-1:0]             level;
    logic                      uart_tx;

    modport master (
        output wen, data_in,
        input  tx_busy, tx_idle, overflow, level, uart_tx
    );

    modport slave (
        input  wen, data_in,
        output tx_busy, tx_idle, overflow, level, uart_tx
    );

endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word fall-through read.
//   clk, reset : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored while full)
//   pop, dout  : read request and head data (dout valid while !empty)
//   full/empty : derived from pointers carrying one extra wrap bit
//   level      : wr_ptr - rd_ptr
//   overflow   : sticky, set by a push while full, cleared only by reset
// A push while full is rejected even when a pop happens on the same edge,
// so that full depends only on registered pointers.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             push_ok;
    logic             pop_ok;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Read is asynchronous so the serializer can load the head byte on the
    // same edge it pops; the array is small enough for distributed RAM.
    assign dout     = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (push & full) begin
            overflow_d = 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset: clearing the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered 8N1 UART transmitter. Bytes written through the bus interface are
// queued in a sync_fifo and serialized LSB first on bus.uart_tx.
//   clk   : CPU clock, rising edge
//   reset : asynchronous active-low reset; line returns high, FIFO emptied
//   bus   : uart_tx_fifo_if.slave (wen, data_in, tx_busy, tx_idle,
//           overflow, level, uart_tx)
// Each bit lasts CPB = CLK_HZ/BAUD clocks; back-to-back frames are separated
// by exactly one IDLE cycle (period 10*CPB+1).
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 27000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);
    localparam int CPB  = uart_cpb(CLK_HZ, BAUD);
    localparam int BW   = $clog2(CPB);
    localparam int LW   = $clog2(DEPTH) + 1;
    localparam int BITW = $clog2(UART_DATA_BITS);

    localparam logic [BW-1:0]   BAUD_LAST = BW'(CPB - 1);
    localparam logic [BITW-1:0] BIT_LAST  = BITW'(UART_DATA_BITS - 1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: DEPTH must be a power of two and >= 2");
        end
        if (CPB < 2) begin : g_bad_cpb
            $error("uart_tx_fifo: CLK_HZ/BAUD must be at least 2");
        end
    endgenerate

    // FIFO connections
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [LW-1:0]             fifo_level;
    logic                      fifo_overflow;

    // Serializer state
    uart_state_t               state_q, state_d;
    logic [BW-1:0]             baud_q, baud_d;
    logic [BITW-1:0]           bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      uart_tx_q, uart_tx_d;
    logic                      tx_idle_q, tx_idle_d;
    logic                      baud_last;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (bus.wen),
        .din      (bus.data_in),
        .pop      (fifo_pop),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level),
        .overflow (fifo_overflow)
    );

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BITW'(1);
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level is registered from the next state and next shift value,
        // so it changes on the same edge as the state and cannot glitch.
        unique case (state_d)
            START:   uart_tx_d = 1'b0;
            DATA:    uart_tx_d = shift_d[0];
            default: uart_tx_d = 1'b1;
        endcase

        // Registered from the current state: drops one edge after the first
        // accepted write and rises one edge after the stop bit ends.
        tx_idle_d = (state_q == IDLE) && fifo_empty;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            uart_tx_q <= 1'b1;
            tx_idle_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            uart_tx_q <= uart_tx_d;
            tx_idle_q <= tx_idle_d;
        end
    end

    assign bus.uart_tx  = uart_tx_q;
    assign bus.tx_busy  = fifo_full;
    assign bus.tx_idle  = tx_idle_q;
    assign bus.overflow = fifo_overflow;
    assign bus.level    = fifo_level;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo at CLK_HZ=1000, BAUD=100 (CPB=10), DEPTH=4.
// Accepted bytes are pushed to an expected queue as they are written; a line
// monitor decodes frames from uart_tx and logs them with their start cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH  = 4;
    localparam int CPB    = 10;
    localparam int PERIOD = 10 * CPB + 1;

    typedef struct {
        logic [7:0] data;
        int         start;
        logic       start_ok;
        logic       stop_ok;
    } frame_t;

    logic clk;
    logic reset;
    int   cyc = 0;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] exp_q [$];
    frame_t     rx_log [64];
    int         rx_cnt = 0;
    int         rx_rd  = 0;

    frame_t mon_f;
    logic   mon_abort;

    int exp_lvl  [6] = '{1, 1, 2, 3, 4, 4};
    int exp_busy [6] = '{0, 0, 0, 0, 1, 1};

    int n0;
    int prev_start;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus_if ();

    uart_tx_fifo #(
        .CLK_HZ (1000),
        .BAUD   (100),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: a frame is recognised at the first low sample while out
    // of reset; bits are sampled at their centres (negedge-based).
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && bus_if.uart_tx === 1'b0) begin
                mon_f.start    = cyc;
                mon_f.start_ok = 1'b1;
                mon_f.stop_ok  = 1'b0;
                mon_f.data     = 8'h00;
                mon_abort      = 1'b0;
                for (int t = 1; t <= 95; t++) begin
                    @(negedge clk);
                    if (reset !== 1'b1) mon_abort = 1'b1;
                    if (t == 5 && bus_if.uart_tx !== 1'b0) mon_f.start_ok = 1'b0;
                    if (t >= 15 && t <= 85 && (t % 10) == 5)
                        mon_f.data[(t - 15) / 10] = bus_if.uart_tx;
                    if (t == 95) mon_f.stop_ok = (bus_if.uart_tx === 1'b1);
                end
                if (!mon_abort && rx_cnt < 64) begin
                    rx_log[rx_cnt] = mon_f;
                    rx_cnt         = rx_cnt + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus_if.wen     = 1'b1;
        bus_if.data_in = b;
        tick();
        bus_if.wen     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int t0;
        t0 = cyc;
        tick();
        while (bus_if.tx_idle !== 1'b1 && (cyc - t0) < budget) tick();
        check("idle_reached", 32'(bus_if.tx_idle), 32'd1);
        repeat (2) tick();
    endtask

    // Pops n expected bytes and compares them with the decoded frames.
    task automatic drain(input int n, input logic spacing);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            check("frame_present", 32'(rx_cnt > rx_rd), 32'd1);
            if (rx_cnt > rx_rd && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("frame_data", 32'(rx_log[rx_rd].data), 32'(e));
                check("frame_start_bit", 32'(rx_log[rx_rd].start_ok), 32'd1);
                check("frame_stop_bit", 32'(rx_log[rx_rd].stop_ok), 32'd1);
                if (spacing && i > 0)
                    check("frame_spacing", rx_log[rx_rd].start - prev_start, PERIOD);
                prev_start = rx_log[rx_rd].start;
                rx_rd++;
            end
        end
        check("no_extra_frames", rx_cnt - rx_rd, 0);
    endtask

    initial begin
        reset          = 1'b0;
        bus_if.wen     = 1'b0;
        bus_if.data_in = 8'h00;

        // 1. Reset values
        repeat (3) tick();
        check("rst_uart_tx_held", 32'(bus_if.uart_tx), 32'd1);
        reset = 1'b1;
        tick();
        check("rst_uart_tx", 32'(bus_if.uart_tx), 32'd1);
        check("rst_tx_busy", 32'(bus_if.tx_busy), 32'd0);
        check("rst_tx_idle", 32'(bus_if.tx_idle), 32'd1);
        check("rst_level", 32'(bus_if.level), 32'd0);
        check("rst_overflow", 32'(bus_if.overflow), 32'd0);

        // 2. Single byte 0x55
        write_byte(8'h55);
        exp_q.push_back(8'h55);
        n0 = cyc;
        check("single_level_after_write", 32'(bus_if.level), 32'd1);
        tick();
        check("single_level_after_pop", 32'(bus_if.level), 32'd0);
        check("single_start_low", 32'(bus_if.uart_tx), 32'd0);
        check("single_tx_idle_drop", 32'(bus_if.tx_idle), 32'd0);
        while (bus_if.tx_idle !== 1'b1 && (cyc - n0) < 300) tick();
        check("single_idle_latency", cyc - n0, 102);
        drain(1, 1'b0);
        check("single_start_cycle", prev_start, n0 + 1);

        // 3. Back-to-back 0x41, 0x42, 0x43
        write_byte(8'h41); exp_q.push_back(8'h41);
        n0 = cyc;
        write_byte(8'h42); exp_q.push_back(8'h42);
        write_byte(8'h43); exp_q.push_back(8'h43);
        wait_idle(600);
        drain(3, 1'b1);

        // 4. Full and overflow: 0x01..0x06, the 6th is dropped
        for (int i = 0; i < 6; i++) begin
            write_byte(8'(i + 1));
            if (i < 5) exp_q.push_back(8'(i + 1));
            check("fill_level", 32'(bus_if.level), exp_lvl[i]);
            check("fill_tx_busy", 32'(bus_if.tx_busy), exp_busy[i]);
        end
        check("fill_overflow", 32'(bus_if.overflow), 32'd1);
        wait_idle(900);
        drain(5, 1'b1);
        check("fill_overflow_sticky", 32'(bus_if.overflow), 32'd1);

        // 5. Push while full coinciding with a pop
        do_reset();
        check("push_pop_overflow_cleared", 32'(bus_if.overflow), 32'd0);
        write_byte(8'hA0); exp_q.push_back(8'hA0);
        n0 = cyc;
        write_byte(8'hB1); exp_q.push_back(8'hB1);
        write_byte(8'hB2); exp_q.push_back(8'hB2);
        write_byte(8'hB3); exp_q.push_back(8'hB3);
        write_byte(8'hB4); exp_q.push_back(8'hB4);
        check("push_pop_full_level", 32'(bus_if.level), 32'd4);
        while (cyc < n0 + PERIOD) tick();
        check("push_pop_level_before", 32'(bus_if.level), 32'd4);
        check("push_pop_busy_before", 32'(bus_if.tx_busy), 32'd1);
        write_byte(8'hEE);
        check("push_pop_level_after", 32'(bus_if.level), 32'd3);
        check("push_pop_overflow", 32'(bus_if.overflow), 32'd1);
        check("push_pop_busy_after", 32'(bus_if.tx_busy), 32'd0);
        check("push_pop_next_start", 32'(bus_if.uart_tx), 32'd0);
        wait_idle(700);
        drain(5, 1'b1);

        // 6. Reset during DATA bit 3 of 0xF0 with two bytes queued
        do_reset();
        write_byte(8'hF0);
        n0 = cyc;
        write_byte(8'h11);
        write_byte(8'h22);
        while (cyc < n0 + 45) tick();
        check("midrst_line_before", 32'(bus_if.uart_tx), 32'd0);
        check("midrst_level_before", 32'(bus_if.level), 32'd2);
        reset = 1'b0;
        #1;
        check("midrst_line_now", 32'(bus_if.uart_tx), 32'd1);
        check("midrst_level_now", 32'(bus_if.level), 32'd0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (300) tick();
        check("midrst_no_frames", rx_cnt - rx_rd, 0);
        check("midrst_line_idle", 32'(bus_if.uart_tx), 32'd1);
        check("midrst_tx_idle", 32'(bus_if.tx_idle), 32'd1);
        check("midrst_level_after", 32'(bus_if.level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
